// File: rtl/alu.sv
// Sequential 32-bit ALU behind a 16-bit port: four half-word operand loads,
// an opcode load, an execute step, then the result read back as two halves.
module alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        nextstate,
   output logic [15:0] out
);

   typedef enum logic [2:0] {
      LOAD_A_LO,
      LOAD_A_HI,
      LOAD_B_LO,
      LOAD_B_HI,
      LOAD_OP,
      EXEC,
      OUT_LO,
      OUT_HI
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] r_q, r_d;
   logic [3:0]  op_q, op_d;
   logic        ns_q;
   logic        advance;
   logic        bigShift;
   logic [31:0] result;

   assign advance = nextstate & ~ns_q;

   // Any set bit above bit 4 means the shift pushes every bit out.
   assign bigShift = |b_q[31:5];

   always_comb begin
      result = 32'h0000_0000;
      unique case (op_q)
         4'd0: result = a_q + b_q;
         4'd1: result = a_q - b_q;
         4'd2: result = a_q & b_q;
         4'd3: result = a_q | b_q;
         4'd4: result = a_q ^ b_q;
         4'd5: result = ~a_q;
         4'd6: result = bigShift ? 32'h0000_0000 : (a_q << b_q[4:0]);
         4'd7: result = bigShift ? {32{a_q[31]}} : 32'($signed(a_q) >>> b_q[4:0]);
         4'd8: result = bigShift ? 32'h0000_0000 : (a_q >> b_q[4:0]);
         default: result = 32'h0000_0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      op_d    = op_q;
      if (advance) begin
         unique case (state_q)
            LOAD_A_LO: begin a_d[15:0]  = in;      state_d = LOAD_A_HI; end
            LOAD_A_HI: begin a_d[31:16] = in;      state_d = LOAD_B_LO; end
            LOAD_B_LO: begin b_d[15:0]  = in;      state_d = LOAD_B_HI; end
            LOAD_B_HI: begin b_d[31:16] = in;      state_d = LOAD_OP;   end
            LOAD_OP:   begin op_d       = in[3:0]; state_d = EXEC;      end
            EXEC:      begin r_d        = result;  state_d = OUT_LO;    end
            OUT_LO:    state_d = OUT_HI;
            OUT_HI:    state_d = OUT_LO;
            default:   state_d = LOAD_A_LO;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LOAD_A_LO;
         a_q     <= 32'h0000_0000;
         b_q     <= 32'h0000_0000;
         r_q     <= 32'h0000_0000;
         op_q    <= 4'h0;
         ns_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         op_q    <= op_d;
         ns_q    <= nextstate;
      end
   end

   // Decoded from state so it drops to zero as soon as reset lands.
   always_comb begin
      out = 16'h0000;
      if (state_q == OUT_LO) out = r_q[15:0];
      else if (state_q == OUT_HI) out = r_q[31:16];
   end

endmodule

// File: tb/tb_alu.sv
// Table-driven bench for alu: each advance pushes its expected out value onto a
// scoreboard queue, which is popped and compared once the DUT has stepped.
module tb_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in;
   logic        nextstate;
   logic [15:0] out;

   int total = 0;
   int bad   = 0;

   logic [15:0] expQ[$];

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   alu dut (
      .clk(clk),
      .reset(reset),
      .in(in),
      .nextstate(nextstate),
      .out(out)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name);
      logic [15:0] e;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, out=%h", name, out);
      end else begin
         e = expQ.pop_front();
         if (out !== e) begin
            bad++;
            $display("FAIL %s: out=%h expected=%h", name, out, e);
         end
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset     = 1'b1;
      nextstate = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One strobe: high across one rising edge, then low for a full cycle at the
   // start of the next call.
   task automatic advance(input logic [15:0] val, input logic [15:0] exp, input string name);
      @(negedge clk);
      in        = val;
      nextstate = 1'b1;
      expQ.push_back(exp);
      @(negedge clk);
      nextstate = 1'b0;
      in        = 16'($urandom);
      checkOutput(name);
   endtask

   task automatic loadOperands(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      advance(a[15:0],  16'h0000, "ldAlo");
      advance(a[31:16], 16'h0000, "ldAhi");
      advance(b[15:0],  16'h0000, "ldBlo");
      advance(b[31:16], 16'h0000, "ldBhi");
      advance({12'h000, op}, 16'h0000, "ldOp");
   endtask

   task automatic applyStimulus(input vec_t v);
      doReset();
      loadOperands(v.a, v.b, v.op);
      advance(16'($urandom), v.r[15:0],  {v.name, "_lo"});
      advance(16'($urandom), v.r[31:16], {v.name, "_hi"});
      advance(16'($urandom), v.r[15:0],  {v.name, "_lo2"});
   endtask

   initial begin
      reset     = 1'b1;
      nextstate = 1'b0;
      in        = 16'h0000;

      vecs.push_back('{"add",    32'h0007_0002, 32'h0003_0003, 4'd0,  32'h000A_0005});
      vecs.push_back('{"subWrap",32'h0003_0003, 32'h000B_0001, 4'd1,  32'hFFF8_0002});
      vecs.push_back('{"and",    32'h0043_0023, 32'h040B_0012, 4'd2,  32'h0003_0002});
      vecs.push_back('{"or",     32'h1234_0000, 32'h0000_5678, 4'd3,  32'h1234_5678});
      vecs.push_back('{"xor",    32'hFF00_FF00, 32'h0F0F_0F0F, 4'd4,  32'hF00F_F00F});
      vecs.push_back('{"not",    32'h0825_220A, 32'h1234_5678, 4'd5,  32'hF7DA_DDF5});
      vecs.push_back('{"sll1",   32'h1805_260A, 32'h0000_0001, 4'd6,  32'h300A_4C14});
      vecs.push_back('{"sra1",   32'hB885_2648, 32'h0000_0001, 4'd7,  32'hDC42_9324});
      vecs.push_back('{"srl1",   32'hB885_2648, 32'h0000_0001, 4'd8,  32'h5C42_9324});
      vecs.push_back('{"sll40",  32'h1805_260A, 32'h0000_0028, 4'd6,  32'h0000_0000});
      vecs.push_back('{"sra40",  32'hB885_2648, 32'h0000_0028, 4'd7,  32'hFFFF_FFFF});
      vecs.push_back('{"srl40",  32'hB885_2648, 32'h0000_0028, 4'd8,  32'h0000_0000});
      vecs.push_back('{"sllHiB", 32'h1805_260A, 32'h0001_0001, 4'd6,  32'h0000_0000});
      vecs.push_back('{"sra0",   32'h8000_0001, 32'h0000_0000, 4'd7,  32'h8000_0001});
      vecs.push_back('{"sra31",  32'h8000_0000, 32'h0000_001F, 4'd7,  32'hFFFF_FFFF});
      vecs.push_back('{"sll31",  32'h0000_0001, 32'h0000_001F, 4'd6,  32'h8000_0000});
      vecs.push_back('{"srl31",  32'h8000_0000, 32'h0000_001F, 4'd8,  32'h0000_0001});
      vecs.push_back('{"op9",    32'h1234_5678, 32'h9ABC_DEF0, 4'd9,  32'h0000_0000});
      vecs.push_back('{"op12",   32'h0825_220A, 32'h0000_0001, 4'd12, 32'h0000_0000});
      vecs.push_back('{"op15",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'h0000_0000});

      repeat (2) @(negedge clk);
      expQ.push_back(16'h0000);
      checkOutput("resetOut");
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Held strobe: out must sit on the high half for all three cycles.
      $display("[TB] held strobe sequence");
      doReset();
      loadOperands(32'h0007_0002, 32'h0003_0003, 4'd0);
      advance(16'h0000, 16'h0005, "holdPre");
      @(negedge clk);
      nextstate = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expQ.push_back(16'h000A);
         checkOutput("holdHigh");
      end
      nextstate = 1'b0;
      advance(16'h0000, 16'h0005, "holdWrap");

      // Async reset from an output state clears out before any clock edge.
      @(negedge clk);
      #2 reset = 1'b1;
      #1 expQ.push_back(16'h0000);
      checkOutput("rstAsyncOut");
      @(negedge clk);
      reset = 1'b0;

      // Reset between LOAD_B_LO and LOAD_B_HI, then a fresh OR load.
      $display("[TB] mid-load reset sequence");
      advance(16'hDEAD, 16'h0000, "midAlo");
      advance(16'hBEEF, 16'h0000, "midAhi");
      advance(16'h1111, 16'h0000, "midBlo");
      @(negedge clk);
      #2 reset = 1'b1;
      #1 expQ.push_back(16'h0000);
      checkOutput("rstMid");
      @(negedge clk);
      reset = 1'b0;
      loadOperands(32'h0000_000A, 32'h0000_0005, 4'd3);
      advance(16'h0000, 16'h000F, "freshLo");
      advance(16'h0000, 16'h0000, "freshHi");

      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL scoreboardDrain: left=%0d expected=0", expQ.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
